pwm_generate: RTL and testbench

//  Transmit-side counterpart of the PWM detector. Drives pwm_out with a programmed high time
//  and low time, both counted in pwd_clk cycles. The MicroBlaze writes high_count and
//  low_count over GPIO; the block double-buffers them and applies a new setting only at a

---
 rtl/pwm_generate.sv | 147 ++++++++++++++
 tb/tb_pwm_generate.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pwm_generate.sv
// pwm_generate
//   Produces a PWM waveform whose high and low times are counted in pwd_clk
//   cycles. A new high/low setting is captured into shadow registers on
//   cfg_load. It is copied into the active registers only when the block
//   leaves IDLE or on the last clock of a period. A running period is therefore
//   never cut short.
//
// Ports
//   pwd_clk      system clock
//   sysreset     synchronous reset, active-high
//   enable       1 = run; 0 = finish the current period, then idle
//   high_count   requested high time in clocks (sampled on cfg_load)
//   low_count    requested low time in clocks (sampled on cfg_load)
//   cfg_load     one-cycle strobe that captures high_count/low_count
//   cfg_pending  shadow holds a setting that has not been applied yet
//   pwm_out      registered PWM output
//   period_done  one-cycle pulse after the last clock of each period
//   cycle_count  completed periods, wraps modulo 2^COUNT_WIDTH
module pwm_generate #(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                   pwd_clk,
    input  logic                   sysreset,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] high_count,
    input  logic [COUNT_WIDTH-1:0] low_count,
    input  logic                   cfg_load,
    output logic                   cfg_pending,
    output logic                   pwm_out,
    output logic                   period_done,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    // The clock frequency is informational only. It is checked for sanity at
    // elaboration time.
    if (CLK_FREQUENCY_HZ <= 0) begin : g_bad_freq
        $error("pwm_generate: CLK_FREQUENCY_HZ must be positive");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] act_h_q, act_l_q;
    logic [COUNT_WIDTH-1:0] sh_h_q, sh_l_q;
    logic                   pend_q;
    logic                   pwm_q, pwm_d;
    logic                   done_q, done_d;
    logic [COUNT_WIDTH-1:0] ccount_q;

    // Config that becomes active if an apply happens this cycle. A load that
    // coincides with the apply bypasses the shadow.
    logic [COUNT_WIDTH-1:0] cfg_h, cfg_l;
    logic                   start, last_clk, apply;

    assign cfg_h = cfg_load ? high_count : (pend_q ? sh_h_q : act_h_q);
    assign cfg_l = cfg_load ? low_count  : (pend_q ? sh_l_q : act_l_q);

    // H+L>0 is tested as an OR so the check never needs a wider adder.
    assign start    = (state_q == IDLE) && enable && ((cfg_h != '0) || (cfg_l != '0));
    assign last_clk = ((state_q == HIGH) && (cnt_q == act_h_q) && (act_l_q == '0)) ||
                      ((state_q == LOW)  && (cnt_q == act_l_q));
    assign apply    = start || last_clk;

    // State and data registers.
    always_ff @(posedge pwd_clk) begin
        if (sysreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_h_q  <= '0;
            act_l_q  <= '0;
            sh_h_q   <= '0;
            sh_l_q   <= '0;
            pend_q   <= 1'b0;
            pwm_q    <= 1'b0;
            done_q   <= 1'b0;
            ccount_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
            if (last_clk) begin
                ccount_q <= ccount_q + 1'b1;
            end
            if (apply) begin
                act_h_q <= cfg_h;
                act_l_q <= cfg_l;
                pend_q  <= 1'b0;
            end else if (cfg_load) begin
                sh_h_q <= high_count;
                sh_l_q <= low_count;
                pend_q <= 1'b1;
            end
        end
    end

    // Next state. Each phase counts from 1 up to its programmed length. The
    // counter never exceeds the programmed value, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = (cfg_h != '0) ? HIGH : LOW;
                    cnt_d   = COUNT_WIDTH'(1);
                end
            end
            HIGH: begin
                if ((cnt_q == act_h_q) && (act_l_q != '0)) begin
                    state_d = LOW;
                    cnt_d   = COUNT_WIDTH'(1);
                end
            end
            LOW: ;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Period end overrides the per-state decision and uses the config
        // being applied this cycle.
        if (last_clk) begin
            cnt_d = COUNT_WIDTH'(1);
            if (!enable)               state_d = IDLE;
            else if (cfg_h != '0)      state_d = HIGH;
            else if (cfg_l != '0)      state_d = LOW;
            else                       state_d = IDLE;
        end
    end

    // Outputs are registered from the current state. pwm_out therefore
    // follows the state by one clock.
    always_comb begin
        pwm_d  = (state_q == HIGH);
        done_d = last_clk;
    end

    assign pwm_out     = pwm_q;
    assign period_done = done_q;
    assign cfg_pending = pend_q;
    assign cycle_count = ccount_q;

endmodule

// File: tb/tb_pwm_generate.sv
module tb_pwm_generate;
    localparam int CW = 4;

    logic          pwd_clk = 1'b0;
    logic          sysreset = 1'b1;
    logic          enable = 1'b0;
    logic          cfg_load = 1'b0;
    logic [CW-1:0] high_count = '0;
    logic [CW-1:0] low_count = '0;
    logic          cfg_pending, pwm_out, period_done;
    logic [CW-1:0] cycle_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] pw, pd, pe;

    pwm_generate #(.CLK_FREQUENCY_HZ(100000000), .COUNT_WIDTH(CW)) dut (
        .pwd_clk    (pwd_clk),
        .sysreset   (sysreset),
        .enable     (enable),
        .high_count (high_count),
        .low_count  (low_count),
        .cfg_load   (cfg_load),
        .cfg_pending(cfg_pending),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .cycle_count(cycle_count)
    );

    always #5 pwd_clk = ~pwd_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pwd_clk);
        #1;
    endtask

    // Runs n clocks. Bit i of each vector is the output seen after clock i.
    // cfg_load is pulsed with lh/ll on clock load_at (-1 = no load).
    task automatic capture(input int n, input int load_at, input logic [CW-1:0] lh,
                           input logic [CW-1:0] ll, output logic [31:0] vpw,
                           output logic [31:0] vpd, output logic [31:0] vpe);
        vpw = '0; vpd = '0; vpe = '0;
        for (int i = 0; i < n; i++) begin
            cfg_load   = (i == load_at);
            high_count = lh;
            low_count  = ll;
            tick();
            cfg_load = 1'b0;
            vpw[i] = pwm_out;
            vpd[i] = period_done;
            vpe[i] = cfg_pending;
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        sysreset = 1'b0;
        chk("rst_pwm", {31'd0, pwm_out}, 0);
        chk("rst_done", {31'd0, period_done}, 0);
        chk("rst_pend", {31'd0, cfg_pending}, 0);
        chk("rst_cc", {28'd0, cycle_count}, 0);

        // 3/5 loaded while idle, then enabled
        capture(1, 0, 4'd3, 4'd5, pw, pd, pe);
        chk("load_pend", pe, 32'h1);
        enable = 1'b1;
        tick();
        chk("start_pend", {31'd0, cfg_pending}, 0);
        chk("start_lat", {31'd0, pwm_out}, 0);
        capture(16, -1, 4'd0, 4'd0, pw, pd, pe);
        chk("p35_pwm", pw, 32'h0707);
        chk("p35_done", pd, 32'h8080);
        chk("p35_cc", {28'd0, cycle_count}, 2);

        // 2/2 loaded mid-period, applied at the boundary
        capture(16, 3, 4'd2, 4'd2, pw, pd, pe);
        chk("swap_pwm", pw, 32'h3307);
        chk("swap_done", pd, 32'h8880);
        chk("swap_pend", pe, 32'h0078);
        chk("swap_cc", {28'd0, cycle_count}, 5);

        // Degenerate 0/4 then 4/0
        capture(16, 0, 4'd0, 4'd4, pw, pd, pe);
        chk("h0_pwm", pw, 32'h0003);
        chk("h0_done", pd, 32'h8888);
        capture(16, 0, 4'd4, 4'd0, pw, pd, pe);
        chk("l0_pwm", pw, 32'hFFF0);
        chk("l0_done", pd, 32'h8888);
        chk("l0_cc", {28'd0, cycle_count}, 13);

        // Back to 3/5, then drop enable on clock 1 of HIGH
        capture(8, 0, 4'd3, 4'd5, pw, pd, pe);
        chk("back_pwm", pw, 32'h007F);
        chk("back_done", pd, 32'h0008);
        tick(); tick(); tick(); tick();
        chk("pre_drop_done", {31'd0, period_done}, 1);
        chk("pre_drop_cc", {28'd0, cycle_count}, 15);
        enable = 1'b0;
        capture(16, -1, 4'd0, 4'd0, pw, pd, pe);
        chk("drop_pwm", pw, 32'h0007);
        chk("drop_done", pd, 32'h0080);
        chk("drop_cc_wrap", {28'd0, cycle_count}, 0);

        // Reset mid-HIGH with a setting pending
        enable = 1'b1;
        tick();
        capture(1, 0, 4'd2, 4'd2, pw, pd, pe);
        chk("prerst_pwm", pw, 32'h1);
        chk("prerst_pend", pe, 32'h1);
        sysreset = 1'b1;
        tick();
        sysreset = 1'b0;
        chk("mrst_pwm", {31'd0, pwm_out}, 0);
        chk("mrst_cc", {28'd0, cycle_count}, 0);
        chk("mrst_pend", {31'd0, cfg_pending}, 0);
        chk("mrst_done", {31'd0, period_done}, 0);
        capture(10, -1, 4'd0, 4'd0, pw, pd, pe);
        chk("mrst_idle_pwm", pw, 32'h0);
        chk("mrst_idle_done", pd, 32'h0);

        // 1/1 loaded on the IDLE exit, count wraps after 16 periods
        capture(32, 0, 4'd1, 4'd1, pw, pd, pe);
        chk("w_pwm", pw, 32'hAAAAAAAA);
        chk("w_done", pd, 32'h55555554);
        chk("w_pend", pe, 32'h0);
        chk("w_cc15", {28'd0, cycle_count}, 15);
        tick();
        chk("w_cc0", {28'd0, cycle_count}, 0);
        chk("w_done16", {31'd0, period_done}, 1);

        // 0/0 while running: finish the period, then stay idle
        capture(16, 0, 4'd0, 4'd0, pw, pd, pe);
        chk("z_pwm", pw, 32'h0001);
        chk("z_done", pd, 32'h0002);
        chk("z_pend", pe, 32'h0001);
        chk("z_cc", {28'd0, cycle_count}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
